// File: rtl/fwd_pkg.sv
// fwd_pkg: slot control type, register-zero constant and DEPTH legality check shared by the forwarding scoreboard
package fwd_pkg;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic ready;
  } slot_ctl_t;
  function automatic bit depth_legal(input int depth);
    return depth >= DEPTH_MIN && depth <= DEPTH_MAX;
  endfunction
endpackage

// File: rtl/fwd_slot.sv
// fwd_slot: one in-flight result slot; shifts its input every cycle and captures load data when told to
// ports: clk, reset (sync active-low), in_ctl/in_regnum/in_data (previous stage), capture + ld_data (load completion), ctl/regnum/data (slot state)
module fwd_slot
  import fwd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  slot_ctl_t          in_ctl,
  input  logic [REGBITS-1:0] in_regnum,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               capture,
  input  logic [WIDTH-1:0]   ld_data,
  output slot_ctl_t          ctl,
  output logic [REGBITS-1:0] regnum,
  output logic [WIDTH-1:0]   data
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctl <= '0;
      regnum <= '0;
      data <= '0;
    end else begin
      ctl <= '{valid: in_ctl.valid, regwrite: in_ctl.regwrite, ready: in_ctl.ready | capture};
      regnum <= in_regnum;
      data <= capture ? ld_data : in_data;
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: DEPTH-slot result pipe giving zero-cycle operand forwarding, load-use stall and register-file writeback
// ports: clk, reset (sync active-low); ex_* issue side, flush, ld_data (data for load in slot 0);
//        rs/rt -> fwd_a_*/fwd_b_* forwarded operands, stall; wb_en/wb_regnum/wb_data commit from the oldest slot
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_regwrite,
  input  logic               ex_is_load,
  input  logic [REGBITS-1:0] ex_wr_regnum,
  input  logic [WIDTH-1:0]   ex_result,
  input  logic [WIDTH-1:0]   ld_data,
  input  logic               flush,
  input  logic [REGBITS-1:0] rs,
  input  logic [REGBITS-1:0] rt,
  output logic               fwd_a_hit,
  output logic               fwd_b_hit,
  output logic [WIDTH-1:0]   fwd_a_data,
  output logic [WIDTH-1:0]   fwd_b_data,
  output logic               stall,
  output logic               wb_en,
  output logic [REGBITS-1:0] wb_regnum,
  output logic [WIDTH-1:0]   wb_data
);
  slot_ctl_t          ctl    [DEPTH];
  logic [REGBITS-1:0] regnum [DEPTH];
  logic [WIDTH-1:0]   data   [DEPTH];
  slot_ctl_t          head_ctl;
  logic               pend_a, pend_b;
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH must lie in 2..8");
  end
  // a stalled or flushed instruction enters as a bubble; writes to register zero are dropped here
  assign head_ctl = '{valid: ex_valid & ~flush & ~stall,
                      regwrite: ex_regwrite & (ex_wr_regnum != REGBITS'(REG_ZERO)),
                      ready: ~ex_is_load};
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    slot_ctl_t          src_ctl;
    logic [REGBITS-1:0] src_regnum;
    logic [WIDTH-1:0]   src_data;
    logic               cap;
    if (i == 0) begin : g_head
      assign src_ctl = head_ctl;
      assign src_regnum = ex_wr_regnum;
      assign src_data = ex_is_load ? '0 : ex_result;
      assign cap = 1'b0;
    end else begin : g_tail
      assign src_ctl = ctl[i-1];
      assign src_regnum = regnum[i-1];
      assign src_data = data[i-1];
      // a load completes on its way from slot 0 to slot 1, so only slot 1 ever captures
      assign cap = (i == 1) && !ctl[0].ready;
    end
    fwd_slot #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_slot (
      .clk(clk),
      .reset(reset),
      .in_ctl(src_ctl),
      .in_regnum(src_regnum),
      .in_data(src_data),
      .capture(cap),
      .ld_data(ld_data),
      .ctl(ctl[i]),
      .regnum(regnum[i]),
      .data(data[i])
    );
  end
  // scan oldest to youngest so the youngest match is the last one written
  always_comb begin
    fwd_a_hit = 1'b0;
    fwd_a_data = '0;
    pend_a = 1'b0;
    fwd_b_hit = 1'b0;
    fwd_b_data = '0;
    pend_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ctl[k].valid && ctl[k].regwrite && regnum[k] == rs && rs != REGBITS'(REG_ZERO)) begin
        fwd_a_hit = ctl[k].ready;
        pend_a = !ctl[k].ready;
        fwd_a_data = ctl[k].ready ? data[k] : '0;
      end
      if (ctl[k].valid && ctl[k].regwrite && regnum[k] == rt && rt != REGBITS'(REG_ZERO)) begin
        fwd_b_hit = ctl[k].ready;
        pend_b = !ctl[k].ready;
        fwd_b_data = ctl[k].ready ? data[k] : '0;
      end
    end
  end
  assign stall = ex_valid & (pend_a | pend_b);
  assign wb_en = ctl[DEPTH-1].valid & ctl[DEPTH-1].regwrite;
  assign wb_regnum = regnum[DEPTH-1];
  assign wb_data = data[DEPTH-1];
endmodule
